// File: rtl/ps2_hack_keyboard.sv
// PS/2 set-2 receiver and decoder: holds the Hack KBD code of the held key (0 = none).
// keycode/key_valid land two clk after the stop-bit sample; no backpressure, the keyboard owns the line.
module ps2_hack_keyboard #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   byte_rdy_q, byte_rdy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [7:0]             keycode_q, keycode_d;
  logic                   key_valid_q, key_valid_d;

  logic       clk_s;
  logic       din;
  logic       fall;
  logic [7:0] mapped;

  function automatic logic [7:0] map_code(input logic ext, input logic [7:0] b);
    logic [7:0] m;
    m = 8'd0;
    if (ext) begin
      case (b)
        8'h6B: m = 8'd130;
        8'h75: m = 8'd131;
        8'h74: m = 8'd132;
        8'h72: m = 8'd133;
        8'h6C: m = 8'd134;
        8'h69: m = 8'd135;
        8'h7D: m = 8'd136;
        8'h7A: m = 8'd137;
        8'h70: m = 8'd138;
        8'h71: m = 8'd139;
        8'h5A: m = 8'd128;
        default: m = 8'd0;
      endcase
    end else begin
      case (b)
        8'h1C: m = 8'd65;  8'h32: m = 8'd66;  8'h21: m = 8'd67;  8'h23: m = 8'd68;
        8'h24: m = 8'd69;  8'h2B: m = 8'd70;  8'h34: m = 8'd71;  8'h33: m = 8'd72;
        8'h43: m = 8'd73;  8'h3B: m = 8'd74;  8'h42: m = 8'd75;  8'h4B: m = 8'd76;
        8'h3A: m = 8'd77;  8'h31: m = 8'd78;  8'h44: m = 8'd79;  8'h4D: m = 8'd80;
        8'h15: m = 8'd81;  8'h2D: m = 8'd82;  8'h1B: m = 8'd83;  8'h2C: m = 8'd84;
        8'h3C: m = 8'd85;  8'h2A: m = 8'd86;  8'h1D: m = 8'd87;  8'h22: m = 8'd88;
        8'h35: m = 8'd89;  8'h1A: m = 8'd90;
        8'h45: m = 8'd48;  8'h16: m = 8'd49;  8'h1E: m = 8'd50;  8'h26: m = 8'd51;
        8'h25: m = 8'd52;  8'h2E: m = 8'd53;  8'h36: m = 8'd54;  8'h3D: m = 8'd55;
        8'h3E: m = 8'd56;  8'h46: m = 8'd57;
        8'h29: m = 8'd32;  8'h5A: m = 8'd128; 8'h66: m = 8'd129; 8'h76: m = 8'd140;
        8'h05: m = 8'd141; 8'h06: m = 8'd142; 8'h04: m = 8'd143; 8'h0C: m = 8'd144;
        8'h03: m = 8'd145; 8'h0B: m = 8'd146; 8'h83: m = 8'd147; 8'h0A: m = 8'd148;
        8'h01: m = 8'd149; 8'h09: m = 8'd150; 8'h78: m = 8'd151; 8'h07: m = 8'd152;
        default: m = 8'd0;
      endcase
    end
    return m;
  endfunction

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign din   = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = '0;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          if (!din) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_ok_d = ^{shift_q, din};
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (par_ok_q && din) byte_rdy_d = 1'b1;
          else                 frame_err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A stalled partial frame is dropped; decoder flags survive so E0/F0 prefixes still apply.
    if (state_q != S_IDLE && !fall) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end
  end

  // shift_q is stable while byte_rdy_q is high: the next start bit does not shift.
  assign mapped = map_code(ext_q, shift_q);

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode_q;
    key_valid_d = 1'b0;
    if (byte_rdy_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          if (mapped == keycode_q) keycode_d = 8'd0;
        end else if (mapped != 8'd0) begin
          keycode_d   = mapped;
          key_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keycode_q   <= 8'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keycode_q   <= keycode_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign keycode     = keycode_q;
  assign key_valid   = key_valid_q;
  assign frame_error = frame_err_q;

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Scoreboard bench for ps2_hack_keyboard: a reference decoder queues expected pulses per frame.
module tb_ps2_hack_keyboard;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_error;

  ps2_hack_keyboard #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .key_valid  (key_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] code;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc = 0;
  int  stop_cyc = 0;

  bit         model_ext = 0;
  bit         model_brk = 0;
  logic [7:0] model_key = 8'd0;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] FKEYS [12] = '{
    8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  localparam logic [7:0] EXT_SC [11] = '{
    8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71, 8'h5A};
  localparam logic [7:0] EXT_VAL [11] = '{
    8'd130, 8'd131, 8'd132, 8'd133, 8'd134, 8'd135, 8'd136, 8'd137, 8'd138, 8'd139, 8'd128};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_map(input bit ext, input logic [7:0] b);
    if (ext) begin
      for (int i = 0; i < 11; i++) if (EXT_SC[i] == b) return EXT_VAL[i];
      return 8'd0;
    end
    for (int i = 0; i < 26; i++) if (LETTERS[i] == b) return 8'(65 + i);
    for (int i = 0; i < 10; i++) if (DIGITS[i] == b) return 8'(48 + i);
    for (int i = 0; i < 12; i++) if (FKEYS[i] == b) return 8'(141 + i);
    if (b == 8'h29) return 8'd32;
    if (b == 8'h5A) return 8'd128;
    if (b == 8'h66) return 8'd129;
    if (b == 8'h76) return 8'd140;
    return 8'd0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] m;
    ev_t e;
    if (b == 8'hE0) model_ext = 1;
    else if (b == 8'hF0) model_brk = 1;
    else begin
      m = ref_map(model_ext, b);
      if (model_brk) begin
        if (m == model_key) model_key = 8'd0;
      end else if (m != 8'd0) begin
        model_key = m;
        e.err = 0;
        e.code = m;
        exp_q.push_back(e);
      end
      model_ext = 0;
      model_brk = 0;
    end
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1;
    e.code = 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v, input bit is_stop);
    ps2_data = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_par) push_err();
    else model_byte(b);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(par, 0);
    ps2_bit(1'b1, 1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    chk($sformatf("pending_after_%02h", b), exp_q.size(), 0);
    chk($sformatf("keycode_after_%02h", b), keycode, model_key);
  endtask

  always @(negedge clk) begin
    if (!reset && (key_valid || frame_error)) begin
      if (key_valid && frame_error) chk("kv_with_err", 1, 0);
      if (exp_q.size() == 0) begin
        chk(key_valid ? "unexpected_kv" : "unexpected_err", 1, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_is_err", int'(frame_error), int'(mon_ev.err));
        if (key_valid) begin
          chk("kv_code", keycode, mon_ev.code);
          chk("kv_latency", cyc - stop_cyc, 4);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] part;
    repeat (5) @(negedge clk);
    chk("rst_keycode", keycode, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);

    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    send_frame(8'h5A, 0);
    send_frame(8'h75, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h5A, 0);

    send_frame(8'h1C, 0);
    send_frame(8'h29, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h29, 0);

    send_frame(8'h1C, 1);
    send_frame(8'h29, 0);
    send_frame(8'h29, 0);

    push_err();
    ps2_bit(1'b0, 0);
    part = 8'h5A;
    for (int i = 0; i < 4; i++) ps2_bit(part[i], 0);
    ps2_data = 1'b1;
    repeat (TMO + 200) @(negedge clk);
    chk("pending_after_timeout", exp_q.size(), 0);
    chk("keycode_after_timeout", keycode, model_key);
    send_frame(8'h5A, 0);

    ps2_bit(1'b0, 0);
    part = 8'h66;
    for (int i = 0; i < 5; i++) ps2_bit(part[i], 0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("keycode_in_midframe_reset", keycode, 0);
    reset = 1'b0;
    model_key = 8'd0;
    model_ext = 0;
    model_brk = 0;
    repeat (10) @(negedge clk);
    send_frame(8'h66, 0);
    send_frame(8'h12, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h12, 0);

    send_frame(8'h83, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h71, 0);

    repeat (20) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
